// File: rtl/usb_rx_bit_decoder.sv
// usb_rx_bit_decoder: USB RX front end - recovers bit timing from oversampled D+/D-,
// NRZI-decodes, unstuffs, and flags SE0 (eop) and bit-stuff violations.
module usb_rx_bit_decoder #(
   parameter int CLKS_PER_BIT = 8,
   parameter int SAMPLE_POINT = 3
) (
   input  logic clk,
   input  logic n_rst,
   input  logic d_plus,
   input  logic d_minus,
   input  logic rcving,
   output logic d_orig,
   output logic shift_en,
   output logic eop,
   output logic stuff_error
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] SP = TW'(SAMPLE_POINT);
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

   logic [TW-1:0] timer_q, timer_d;
   logic [2:0] ones_q, ones_d;
   logic dp_prev_q, last_dp_q, last_dp_d;
   logic d_orig_q, d_orig_d, shift_en_q, shift_en_d, eop_q, eop_d, stuff_error_q, stuff_error_d;
   logic edge_det, samp, raw, se0, full;

   always_comb begin
      edge_det = rcving & (d_plus ^ dp_prev_q);
      samp = rcving & (timer_q == SP) & ~edge_det;
      se0 = ~d_plus & ~d_minus;
      raw = ~(d_plus ^ last_dp_q);
      full = ones_q == 3'd6;
      // the edge cycle is count 0, so the sample lands SAMPLE_POINT clocks after the transition
      timer_d = !rcving ? '0 : edge_det ? TW'(1) : (timer_q == LAST) ? '0 : timer_q + TW'(1);
      eop_d = samp & se0;
      shift_en_d = samp & ~se0 & ~full;
      stuff_error_d = samp & ~se0 & full & raw;
      d_orig_d = shift_en_d ? raw : d_orig_q;
      last_dp_d = !rcving ? 1'b1 : (samp & ~se0) ? d_plus : last_dp_q;
      ones_d = !rcving ? 3'd0 : !samp ? ones_q : (shift_en_d & raw) ? ones_q + 3'd1 : 3'd0;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         dp_prev_q <= 1'b1;
         timer_q <= '0;
         ones_q <= 3'd0;
         last_dp_q <= 1'b1;
         d_orig_q <= 1'b1;
         shift_en_q <= 1'b0;
         eop_q <= 1'b0;
         stuff_error_q <= 1'b0;
      end else begin
         dp_prev_q <= d_plus;
         timer_q <= timer_d;
         ones_q <= ones_d;
         last_dp_q <= last_dp_d;
         d_orig_q <= d_orig_d;
         shift_en_q <= shift_en_d;
         eop_q <= eop_d;
         stuff_error_q <= stuff_error_d;
      end
   end

   assign d_orig = d_orig_q;
   assign shift_en = shift_en_q;
   assign eop = eop_q;
   assign stuff_error = stuff_error_q;
endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// tb_usb_rx_bit_decoder: randomized and directed checks of the USB RX bit decoder
// against a bit-level NRZI/unstuffing reference model with per-event timing.
module tb_usb_rx_bit_decoder;
   localparam int CPB = 8;
   localparam int SPT = 3;

   logic clk = 1'b0, n_rst = 1'b0, d_plus = 1'b1, d_minus = 1'b0, rcving = 1'b0;
   logic d_orig, shift_en, eop, stuff_error;
   int cyc = 0, start = 0, ncmp = 0, nfail = 0;
   bit rec = 1'b0;
   int obs_q[$], exp_q[$];

   usb_rx_bit_decoder #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(SPT)) dut (
      .clk(clk), .n_rst(n_rst), .d_plus(d_plus), .d_minus(d_minus), .rcving(rcving),
      .d_orig(d_orig), .shift_en(shift_en), .eop(eop), .stuff_error(stuff_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // event word: cycle offset from packet start, kind (1 shift, 2 eop, 3 stuff error, 0 illegal mix), data bit
   function automatic int ev(int rel, int ty, bit d);
      return rel * 8 + ty * 2 + int'(d);
   endfunction

   function automatic int s(int w, bit dp, bit dm);
      return (w << 2) | (int'(dp) << 1) | int'(dm);
   endfunction

   always @(negedge clk)
      if (rec && (shift_en || eop || stuff_error))
         obs_q.push_back(ev(cyc - start,
            {shift_en, eop, stuff_error} == 3'b100 ? 1 :
            {shift_en, eop, stuff_error} == 3'b010 ? 2 :
            {shift_en, eop, stuff_error} == 3'b001 ? 3 : 0, shift_en & d_orig));

   // expand symbols to a per-cycle line trace, predict events, then drive the trace with rcving high
   task automatic play(input int syms[$]);
      bit lp[$], lm[$];
      int e = 0, ones = 0;
      bit prev = 1'b1, last = 1'b1, raw;
      foreach (syms[i]) repeat (syms[i] >> 2) begin
         lp.push_back(syms[i][1]);
         lm.push_back(syms[i][0]);
      end
      exp_q.delete();
      obs_q.delete();
      for (int c = 0; c < lp.size(); c++) begin
         if (lp[c] != prev) e = c;
         else if ((c - e) % CPB == SPT) begin
            if (!lp[c] && !lm[c]) begin
               exp_q.push_back(ev(c + 1, 2, 1'b0));
               ones = 0;
            end else begin
               raw = lp[c] == last;
               last = lp[c];
               if (ones < 6) begin
                  exp_q.push_back(ev(c + 1, 1, raw));
                  ones = raw ? ones + 1 : 0;
               end else begin
                  if (raw) exp_q.push_back(ev(c + 1, 3, 1'b0));
                  ones = 0;
               end
            end
         end
         prev = lp[c];
      end
      start = cyc;
      rec = 1'b1;
      foreach (lp[c]) begin
         d_plus = lp[c];
         d_minus = lm[c];
         rcving = 1'b1;
         @(posedge clk); #1;
      end
      rcving = 1'b0;
      d_plus = 1'b1;
      d_minus = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rec = 1'b0;
   endtask

   task automatic test_reset();
      int q[$];
      n_rst = 1'b0;
      rcving = 1'b1;
      for (int i = 0; i < 5; i++) begin
         d_plus = 1'($urandom);
         d_minus = 1'($urandom);
         @(posedge clk); #1;
         ncmp++;
         if ({d_orig, shift_en, eop, stuff_error} !== 4'b1000) begin
            nfail++;
            $display("FAIL reset_hold %0d: got %b expected 1000", i, {d_orig, shift_en, eop, stuff_error});
         end
      end
      @(posedge clk); #1;
      n_rst = 1'b1;
      d_plus = 1'b0;
      d_minus = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      #2 n_rst = 1'b0;
      #1;
      ncmp++;
      if ({d_orig, shift_en, eop, stuff_error} !== 4'b1000) begin
         nfail++;
         $display("FAIL reset_midpacket: got %b expected 1000", {d_orig, shift_en, eop, stuff_error});
      end
      d_plus = 1'b1;
      d_minus = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      n_rst = 1'b1;
      q = {s(8, 1, 0), s(8, 1, 0), s(8, 1, 0), s(8, 1, 0), s(8, 1, 0), s(8, 1, 0), s(8, 1, 0), s(8, 1, 0)};
      play(q);
      ncmp++;
      if (obs_q.size() != exp_q.size()) begin
         nfail++;
         $display("FAIL reset_release count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         ncmp++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            nfail++;
            $display("FAIL reset_release ev%0d: got %0d expected %0d", i, i < obs_q.size() ? obs_q[i] : -1, exp_q[i]);
         end
      end
   endtask

   task automatic test_sync();
      int q[$];
      q = {s(8, 0, 1), s(8, 1, 0), s(8, 0, 1), s(8, 1, 0), s(8, 0, 1), s(8, 1, 0), s(8, 0, 1), s(8, 0, 1)};
      play(q);
      ncmp++;
      if (obs_q.size() != 8) begin
         nfail++;
         $display("FAIL sync count: got %0d expected 8", obs_q.size());
      end
      foreach (exp_q[i]) begin
         ncmp++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            nfail++;
            $display("FAIL sync ev%0d: got %0d expected %0d", i, i < obs_q.size() ? obs_q[i] : -1, exp_q[i]);
         end
      end
   endtask

   task automatic test_stuff();
      int q[$];
      q = {s(8, 0, 1), s(8, 1, 0)};
      repeat (6) q.push_back(s(8, 1, 0));
      q = {q, s(8, 0, 1), s(8, 0, 1), s(8, 1, 0)};
      play(q);
      ncmp++;
      if (obs_q.size() != exp_q.size()) begin
         nfail++;
         $display("FAIL stuff count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         ncmp++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            nfail++;
            $display("FAIL stuff ev%0d: got %0d expected %0d", i, i < obs_q.size() ? obs_q[i] : -1, exp_q[i]);
         end
      end
   endtask

   task automatic test_stuff_error();
      int q[$];
      q = {s(8, 0, 1), s(8, 1, 0)};
      repeat (7) q.push_back(s(8, 1, 0));
      q = {q, s(8, 0, 1), s(8, 0, 1)};
      play(q);
      ncmp++;
      if (obs_q.size() != exp_q.size()) begin
         nfail++;
         $display("FAIL stuff_err count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         ncmp++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            nfail++;
            $display("FAIL stuff_err ev%0d: got %0d expected %0d", i, i < obs_q.size() ? obs_q[i] : -1, exp_q[i]);
         end
      end
   endtask

   task automatic test_se0();
      int q[$];
      q = {s(8, 0, 1), s(8, 1, 0), s(8, 0, 0), s(8, 0, 0), s(8, 1, 0), s(8, 0, 1), s(8, 1, 1)};
      play(q);
      ncmp++;
      if (obs_q.size() != exp_q.size()) begin
         nfail++;
         $display("FAIL se0 count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         ncmp++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            nfail++;
            $display("FAIL se0 ev%0d: got %0d expected %0d", i, i < obs_q.size() ? obs_q[i] : -1, exp_q[i]);
         end
      end
   endtask

   task automatic test_resync();
      int q[$];
      q = {s(8, 0, 1), s(8, 1, 0), s(6, 0, 1), s(8, 1, 0), s(8, 1, 0), s(6, 0, 1), s(8, 1, 0)};
      play(q);
      ncmp++;
      if (obs_q.size() != exp_q.size()) begin
         nfail++;
         $display("FAIL resync count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         ncmp++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            nfail++;
            $display("FAIL resync ev%0d: got %0d expected %0d", i, i < obs_q.size() ? obs_q[i] : -1, exp_q[i]);
         end
      end
   endtask

   task automatic test_rcving_drop();
      obs_q.delete();
      exp_q = {ev(4, 1, 1'b0), ev(12, 1, 1'b0)};
      start = cyc;
      rec = 1'b1;
      d_plus = 1'b0; d_minus = 1'b1; rcving = 1'b1;
      repeat (8) begin @(posedge clk); #1; end
      d_plus = 1'b1; d_minus = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      d_plus = 1'b0; d_minus = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rcving = 1'b0;
      @(posedge clk); #1;
      ncmp++;
      if (dut.timer_q !== '0) begin
         nfail++;
         $display("FAIL drop_timer: got %0d expected 0", dut.timer_q);
      end
      for (int i = 0; i < 40; i++) begin
         if (i % 5 == 0) d_plus = ~d_plus;
         d_minus = ~d_plus;
         @(posedge clk); #1;
      end
      d_plus = 1'b1; d_minus = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rec = 1'b0;
      ncmp++;
      if (obs_q.size() != exp_q.size()) begin
         nfail++;
         $display("FAIL drop count: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
         ncmp++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            nfail++;
            $display("FAIL drop ev%0d: got %0d expected %0d", i, i < obs_q.size() ? obs_q[i] : -1, exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      int q[$];
      int r;
      bit prev, dp, dm;
      for (int p = 0; p < 6; p++) begin
         q = {s(8, 0, 1)};
         prev = 1'b0;
         for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 11));
            dp = r == 0 ? 1'b0 : r < 6 ? prev : ~prev;
            dm = r == 0 ? 1'b0 : dp ? (r == 11) : 1'b1;
            q.push_back(s(int'($urandom_range(7, 9)), dp, dm));
            prev = dp;
         end
         play(q);
         ncmp++;
         if (obs_q.size() != exp_q.size()) begin
            nfail++;
            $display("FAIL random%0d count: got %0d expected %0d", p, obs_q.size(), exp_q.size());
         end
         foreach (exp_q[i]) begin
            ncmp++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
               nfail++;
               $display("FAIL random%0d ev%0d: got %0d expected %0d", p, i, i < obs_q.size() ? obs_q[i] : -1, exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_sync();
      test_stuff();
      test_stuff_error();
      test_se0();
      test_resync();
      test_rcving_drop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
